// File: rtl/hm_disp_pkg.sv
// rtl/hm_disp_pkg.sv - shared types and constants for the health-monitor display scan controller.
package hm_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
    localparam logic [0:9][6:0] GLYPH_TBL = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam int NDIG_RT_DEF = 4;
    localparam int NDIG_PM_DEF = 3;

endpackage

// File: rtl/hm_seg7_glyph.sv
// rtl/hm_seg7_glyph.sv - combinational BCD nibble to active-low 7-segment lookup.
module hm_seg7_glyph
    import hm_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_l
);

    // Non-decimal nibbles leave the digit dark rather than showing hex.
    always_comb begin
        seg_l = SEG_OFF;
        if (nibble <= 4'd9) begin
            seg_l = GLYPH_TBL[nibble];
        end
    end

endmodule

// File: rtl/hm_disp_scan_ctrl.sv
// rtl/hm_disp_scan_ctrl.sv - multiplexed 7-segment scan controller with guard blanking and frame snapshot.
// Optional leading-zero blanking is built when HM_DISP_LZB_EN is defined.
module hm_disp_scan_ctrl
    import hm_disp_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int NDIG_RT      = NDIG_RT_DEF,
    parameter int NDIG_PM      = NDIG_PM_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        rs_en,
    input  logic [15:0] digit_in,
    output logic [2:0]  a,
    output logic [6:0]  seg_l,
    output logic        blank,
    output logic        frame_start
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t state;
    logic [CW-1:0] cnt;
    logic [15:0]   snapshot;
    logic          mode_q;

    logic          active;
    logic [2:0]    ndig_last;
    logic          mode_chg;
    logic          pre_end;
    logic          grd_end;
    logic          frame_load;
    logic          digit_adv;
    logic [2:0]    nxt_a;
    logic [15:0]   nxt_snap;
    logic [3:0]    nxt_nibble;
    logic          lz_blank;
    logic [6:0]    glyph_seg;
    logic [6:0]    disp_seg;

    // Next-digit selection is resolved combinationally so the registered
    // segment pattern is already correct on the first DISP cycle.
    always_comb begin
        active    = rs_en | mode;
        ndig_last = mode ? 3'(NDIG_PM - 1) : 3'(NDIG_RT - 1);
        mode_chg  = (state != ST_IDLE) && (mode != mode_q);
        pre_end   = (state == ST_DISP)  && (cnt == PRE_LAST);
        grd_end   = (state == ST_GUARD) && (cnt == BLK_LAST);

        frame_load = active && ((state == ST_IDLE) || mode_chg ||
                                (grd_end && (a >= ndig_last)));
        digit_adv  = active && !mode_chg && grd_end && (a < ndig_last);

        nxt_a = a;
        if (frame_load) begin
            nxt_a = 3'd0;
        end else if (digit_adv) begin
            nxt_a = a + 3'd1;
        end

        nxt_snap   = frame_load ? digit_in : snapshot;
        nxt_nibble = nxt_snap[{nxt_a[1:0], 2'b00} +: 4];

`ifdef HM_DISP_LZB_EN
        // A digit is dark when it and every scanned digit above it are zero.
        lz_blank = (nxt_a != 3'd0);
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) >= nxt_a) && (3'(i) <= ndig_last) &&
                (nxt_snap[4*i +: 4] != 4'd0)) begin
                lz_blank = 1'b0;
            end
        end
`else
        lz_blank = 1'b0;
`endif

        disp_seg = lz_blank ? SEG_OFF : glyph_seg;
    end

    hm_seg7_glyph u_glyph (
        .nibble (nxt_nibble),
        .seg_l  (glyph_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a           <= 3'd0;
            seg_l       <= SEG_OFF;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            cnt         <= '0;
            snapshot    <= 16'h0000;
            mode_q      <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            mode_q      <= mode;
            if (!active) begin
                state <= ST_IDLE;
                a     <= 3'd0;
                seg_l <= SEG_OFF;
                blank <= 1'b1;
                cnt   <= '0;
            end else if (frame_load) begin
                // Covers first start, mode restart and normal frame wrap.
                state       <= ST_DISP;
                a           <= 3'd0;
                snapshot    <= digit_in;
                cnt         <= '0;
                blank       <= 1'b0;
                seg_l       <= disp_seg;
                frame_start <= 1'b1;
            end else begin
                case (state)
                    ST_DISP: begin
                        if (pre_end) begin
                            state <= ST_GUARD;
                            cnt   <= '0;
                            blank <= 1'b1;
                            seg_l <= SEG_OFF;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (grd_end) begin
                            state <= ST_DISP;
                            a     <= nxt_a;
                            cnt   <= '0;
                            blank <= 1'b0;
                            seg_l <= disp_seg;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        a     <= 3'd0;
                        seg_l <= SEG_OFF;
                        blank <= 1'b1;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hm_disp_scan_ctrl.sv
// tb/tb_hm_disp_scan_ctrl.sv - directed self-checking bench for hm_disp_scan_ctrl (PRESCALE=4, BLANK_CYCLES=2).
module tb_hm_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        rs_en;
    logic [15:0] digit_in;
    logic [2:0]  a;
    logic [6:0]  seg_l;
    logic        blank;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    logic [6:0] gl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    hm_disp_scan_ctrl #(
        .PRESCALE     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .rs_en       (rs_en),
        .digit_in    (digit_in),
        .a           (a),
        .seg_l       (seg_l),
        .blank       (blank),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input int nd);
        logic [3:0] nib;
        nib = v[4*d +: 4];
`ifdef HM_DISP_LZB_EN
        if (d != 0) begin
            logic all_zero;
            all_zero = 1'b1;
            for (int j = d; j < nd; j++) begin
                if (v[4*j +: 4] != 4'd0) all_zero = 1'b0;
            end
            if (all_zero) return 7'h7F;
        end
`endif
        if (nib > 4'd9) return 7'h7F;
        return gl[nib];
    endfunction

    // Each digit: 4 DISP cycles then 2 GUARD cycles; k=1 is the cycle after the frame start edge.
    task automatic scan(input string name, input int ncyc, input int nd,
                        input logic [15:0] v0, input logic [15:0] v1, input int chg_k);
        for (int k = 1; k <= ncyc; k++) begin
            int t;
            int d;
            int ph;
            logic [15:0] v;
            @(negedge clk);
            t  = (k - 1) % (nd * 6);
            d  = t / 6;
            ph = t % 6;
            v  = ((k - 1) < nd * 6) ? v0 : v1;
            chk($sformatf("%s_a k=%0d", name, k), 32'(a), 32'(d));
            chk($sformatf("%s_blank k=%0d", name, k), 32'(blank), 32'(ph >= 4));
            chk($sformatf("%s_fs k=%0d", name, k), 32'(frame_start), 32'(t == 0));
            chk($sformatf("%s_seg k=%0d", name, k), 32'(seg_l),
                32'((ph >= 4) ? 7'h7F : exp_seg(v, d, nd)));
            if (k == chg_k) digit_in = v1;
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_a"}, 32'(a), 32'd0);
        chk({name, "_seg"}, 32'(seg_l), 32'h7F);
        chk({name, "_blank"}, 32'(blank), 32'd1);
        chk({name, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 1'b0;
        rs_en    = 1'b1;
        digit_in = 16'h1234;
        repeat (3) @(negedge clk);
        chk_idle("reset");

        rst_n = 1'b1;
        scan("rt1234", 30, 4, 16'h1234, 16'h1234, 0);

        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        scan("rt_rerun", 8, 4, 16'h1234, 16'h1234, 0);

        mode     = 1'b1;
        rs_en    = 1'b0;
        digit_in = 16'h0072;
        scan("pm0072", 40, 3, 16'h0072, 16'h0072, 0);

        mode     = 1'b0;
        rs_en    = 1'b1;
        digit_in = 16'h1111;
        scan("tear", 40, 4, 16'h1111, 16'h9999, 7);

        chk("tear_at_digit2", 32'(a), 32'd2);
        rs_en = 1'b0;
        @(negedge clk);
        chk_idle("rs_fall");
        @(negedge clk);
        chk_idle("rs_idle");
        rs_en = 1'b1;
        scan("reen", 22, 4, 16'h9999, 16'h9999, 0);

        chk("mchg_at_digit3", 32'(a), 32'd3);
        mode     = 1'b1;
        digit_in = 16'h1234;
        scan("mchg", 20, 3, 16'h1234, 16'h1234, 0);

        mode     = 1'b0;
        digit_in = 16'h0050;
        scan("lzb", 48, 4, 16'h0050, 16'h0000, 1);

        rst_n = 1'b0;
        rs_en = 1'b0;
        mode  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("inactive_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
